// File: rtl/sponge_padder_pkg.sv
// sponge_pkg
//   Shared definitions for the sponge padder: mode encodings, rate lookup,
//   domain-suffix / pad-end bytes, the widest block size and the FSM states.
package sponge_pkg;

    // Widest block (SHAKE128 rate).
    localparam int MAX_RATE = 1344;

    localparam logic [2:0] MODE_SHA3_224 = 3'd0;
    localparam logic [2:0] MODE_SHA3_256 = 3'd1;
    localparam logic [2:0] MODE_SHA3_384 = 3'd2;
    localparam logic [2:0] MODE_SHA3_512 = 3'd3;
    localparam logic [2:0] MODE_SHAKE128 = 3'd4;
    localparam logic [2:0] MODE_SHAKE256 = 3'd5;

    localparam logic [7:0] SFX_SHA3  = 8'h06;
    localparam logic [7:0] SFX_SHAKE = 8'h1F;
    localparam logic [7:0] PAD_END   = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ABSORB,
        ST_FULL
    } state_t;

    // Rate in bits; the two unused encodings alias SHA3-256.
    function automatic int rate_bits(input logic [2:0] mode);
        int r;
        case (mode)
            MODE_SHA3_224: r = 1152;
            MODE_SHA3_256: r = 1088;
            MODE_SHA3_384: r = 832;
            MODE_SHA3_512: r = 576;
            MODE_SHAKE128: r = 1344;
            MODE_SHAKE256: r = 1088;
            default:       r = 1088;
        endcase
        return r;
    endfunction

    function automatic int rate_words(input logic [2:0] mode, input int in_w);
        return rate_bits(mode) / in_w;
    endfunction

    function automatic logic is_shake(input logic [2:0] mode);
        return (mode == MODE_SHAKE128) || (mode == MODE_SHAKE256);
    endfunction

endpackage

// File: rtl/sponge_padder_if.sv
// sponge_padder_if
//   Message-in and block-out handshakes of the sponge padder.
//   master: message source / permutation core side (drives start, mode,
//           in_valid, in, is_last, byte_num, blk_ready).
//   slave : the padder (drives ack, blk, blk_valid, blk_last, busy, done).
interface sponge_padder_if #(
    parameter int IN_W     = 64,
    parameter int MAX_RATE = sponge_pkg::MAX_RATE
);
    localparam int BN_W = $clog2(IN_W / 8) + 1;

    logic                start;
    logic [2:0]          mode;
    logic                in_valid;
    logic [IN_W-1:0]     in;
    logic                is_last;
    logic [BN_W-1:0]     byte_num;
    logic                ack;
    logic [MAX_RATE-1:0] blk;
    logic                blk_valid;
    logic                blk_ready;
    logic                blk_last;
    logic                busy;
    logic                done;

    modport master (
        output start, mode, in_valid, in, is_last, byte_num, blk_ready,
        input  ack, blk, blk_valid, blk_last, busy, done
    );

    modport slave (
        input  start, mode, in_valid, in, is_last, byte_num, blk_ready,
        output ack, blk, blk_valid, blk_last, busy, done
    );

endinterface

// File: rtl/sponge_padder_pad_word.sv
// sponge_pad_word
//   Combinational masking/padding of one message word.
//   in_word  : raw message word, byte k at [8k+7:8k]
//   byte_num : number of valid bytes; bytes at or above it are zeroed and the
//              suffix is ORed into byte byte_num (no suffix when byte_num
//              equals the word size)
//   suffix   : domain suffix byte
//   is_final : word is the last one of the rate; ORs PAD_END into its top byte
//   out_word : masked, padded word
module sponge_pad_word #(
    parameter int IN_W = 64,
    parameter int BN_W = $clog2(IN_W / 8) + 1
) (
    input  logic [IN_W-1:0] in_word,
    input  logic [BN_W-1:0] byte_num,
    input  logic [7:0]      suffix,
    input  logic            is_final,
    output logic [IN_W-1:0] out_word
);
    import sponge_pkg::*;

    localparam int NB = IN_W / 8;

    always_comb begin
        out_word = '0;
        for (int k = 0; k < NB; k++) begin
            if (BN_W'(k) < byte_num) begin
                out_word[8*k +: 8] = in_word[8*k +: 8];
            end
            if (BN_W'(k) == byte_num) begin
                out_word[8*k +: 8] = out_word[8*k +: 8] | suffix;
            end
        end
        // Suffix and pad end may share the top byte (0x86 / 0x9F).
        if (is_final) begin
            out_word[IN_W-1 -: 8] = out_word[IN_W-1 -: 8] | PAD_END;
        end
    end

endmodule

// File: rtl/sponge_padder.sv
// sponge_padder
//   Keccak sponge absorb front-end: packs IN_W-bit message words into
//   rate-sized blocks, applies pad10*1 with the SHA3/SHAKE domain suffix and
//   hands each block to the permutation core.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : sponge_padder_if.slave (message in, block out, status)
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | no message; waiting for start
//   ST_ABSORB | ack=1, one word written per cycle at index cnt
//   ST_FULL   | blk_valid=1, block held until blk_ready
module sponge_padder #(
    parameter int IN_W     = 64,
    parameter int MAX_RATE = sponge_pkg::MAX_RATE
) (
    input  logic           clk,
    input  logic           rst,
    sponge_padder_if.slave bus
);
    import sponge_pkg::*;

    localparam int NB    = IN_W / 8;
    localparam int BN_W  = $clog2(NB) + 1;
    localparam int CNT_W = $clog2(MAX_RATE / IN_W + 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          mode_q, mode_d;
    logic                pend_pad_q, pend_pad_d;
    logic [MAX_RATE-1:0] blk_q, blk_d;
    logic                blk_last_q, blk_last_d;
    logic                done_q, done_d;

    logic [CNT_W-1:0]    words_c;
    logic [7:0]          sfx_c;
    int                  cur_base;
    int                  pad_end_pos;
    logic                at_final;
    logic                full_last;
    logic                pw_final;
    logic [BN_W-1:0]     pw_byte_num;
    logic [IN_W-1:0]     pw_out;

    assign words_c     = CNT_W'(rate_words(mode_q, IN_W));
    assign sfx_c       = is_shake(mode_q) ? SFX_SHAKE : SFX_SHA3;
    assign cur_base    = int'(cnt_q) * IN_W;
    assign pad_end_pos = rate_bits(mode_q) - 8;
    assign at_final    = (cnt_q == words_c - 1'b1);
    assign full_last   = (bus.byte_num == BN_W'(NB));

    // Non-last words pass through unmasked; a full last word on the final
    // slot gets no padding here because the pad-only block carries it.
    assign pw_byte_num = bus.is_last ? bus.byte_num : BN_W'(NB);
    assign pw_final    = bus.is_last && at_final && !full_last;

    sponge_pad_word #(
        .IN_W (IN_W),
        .BN_W (BN_W)
    ) u_pad_word (
        .in_word  (bus.in),
        .byte_num (pw_byte_num),
        .suffix   (sfx_c),
        .is_final (pw_final),
        .out_word (pw_out)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        pend_pad_d = pend_pad_q;
        blk_d      = blk_q;
        blk_last_d = blk_last_q;
        done_d     = 1'b0;

        if (bus.start) begin
            state_d    = ST_ABSORB;
            cnt_d      = '0;
            mode_d     = bus.mode;
            pend_pad_d = 1'b0;
            blk_d      = '0;
            blk_last_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                end
                ST_ABSORB: begin
                    if (bus.in_valid) begin
                        blk_d[cur_base +: IN_W] = pw_out;
                        if (!bus.is_last) begin
                            if (at_final) begin
                                state_d    = ST_FULL;
                                blk_last_d = 1'b0;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end else if (at_final && full_last) begin
                            state_d    = ST_FULL;
                            blk_last_d = 1'b0;
                            pend_pad_d = 1'b1;
                        end else begin
                            // A full last word pushes the suffix into byte 0
                            // of the next word slot.
                            if (full_last) begin
                                blk_d[cur_base + IN_W +: 8] = blk_d[cur_base + IN_W +: 8] | sfx_c;
                            end
                            if (!at_final) begin
                                blk_d[pad_end_pos +: 8] = blk_d[pad_end_pos +: 8] | PAD_END;
                            end
                            state_d    = ST_FULL;
                            blk_last_d = 1'b1;
                        end
                    end
                end
                ST_FULL: begin
                    if (bus.blk_ready) begin
                        if (blk_last_q) begin
                            state_d    = ST_IDLE;
                            blk_last_d = 1'b0;
                            done_d     = 1'b1;
                        end else if (pend_pad_q) begin
                            blk_d                   = '0;
                            blk_d[7:0]              = sfx_c;
                            blk_d[pad_end_pos +: 8] = PAD_END;
                            blk_last_d              = 1'b1;
                            pend_pad_d              = 1'b0;
                        end else begin
                            state_d = ST_ABSORB;
                            cnt_d   = '0;
                            blk_d   = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mode_q     <= '0;
            pend_pad_q <= 1'b0;
            blk_q      <= '0;
            blk_last_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            pend_pad_q <= pend_pad_d;
            blk_q      <= blk_d;
            blk_last_q <= blk_last_d;
            done_q     <= done_d;
        end
    end

    assign bus.ack       = (state_q == ST_ABSORB);
    assign bus.blk       = blk_q;
    assign bus.blk_valid = (state_q == ST_FULL);
    assign bus.blk_last  = blk_last_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done_q;

endmodule

// File: tb/tb_sponge_padder.sv
module tb_sponge_padder;
    localparam int IN_W = 64;
    localparam int NB   = IN_W / 8;
    localparam int MAXR = 1344;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sponge_padder_if #(.IN_W(IN_W), .MAX_RATE(MAXR)) bif ();

    sponge_padder #(.IN_W(IN_W), .MAX_RATE(MAXR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int errors = 0;
    int checks = 0;

    logic [MAXR-1:0] exp_blk_q[$];
    bit              exp_last_q[$];

    typedef struct {
        logic [2:0] mode;
        int         nw;
        int         bn;
        int         stall;
        bit         abort_pre;
        int         blocks;
        int         sfx_idx;
        logic [7:0] sfx_val;
        int         end_idx;
        logic [7:0] end_val;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    task automatic chk_blk(input string nm, input logic [MAXR-1:0] act, input logic [MAXR-1:0] want);
        int first;
        first = 0;
        checks++;
        if (act !== want) begin
            errors++;
            for (int j = MAXR/8 - 1; j >= 0; j--)
                if (act[8*j +: 8] !== want[8*j +: 8]) first = j;
            $display("FAIL %s: byte %0d got %02h expected %02h", nm, first,
                     act[8*first +: 8], want[8*first +: 8]);
        end
    endtask

    function automatic int ref_rate_bytes(input logic [2:0] md);
        case (md)
            3'd0:    return 144;
            3'd1:    return 136;
            3'd2:    return 104;
            3'd3:    return 72;
            3'd4:    return 168;
            3'd5:    return 136;
            default: return 136;
        endcase
    endfunction

    // Byte-level pad10*1: message || suffix || 0* with 0x80 ORed into the
    // last byte of the final rate block.
    task automatic build_expected(input logic [2:0] md, input byte unsigned msg[$]);
        byte unsigned    p[$];
        int              r;
        logic [MAXR-1:0] b;
        r = ref_rate_bytes(md);
        p = msg;
        p.push_back((md == 3'd4 || md == 3'd5) ? 8'h1F : 8'h06);
        while (p.size() % r != 0) p.push_back(8'h00);
        p[p.size()-1] = p[p.size()-1] | 8'h80;
        exp_blk_q.delete();
        exp_last_q.delete();
        for (int s = 0; s < p.size(); s += r) begin
            b = '0;
            for (int j = 0; j < r; j++) b[8*j +: 8] = p[s+j];
            exp_blk_q.push_back(b);
            exp_last_q.push_back(s + r == p.size());
        end
    endtask

    task automatic run_msg(input logic [2:0] md, input int nw, input int bn, input int rdy_pct,
                           input int vld_pct, input int stall,
                           output logic [MAXR-1:0] last_blk, output int nblk);
        byte unsigned    msg[$];
        logic [IN_W-1:0] words[$];
        logic [IN_W-1:0] w;
        logic [MAXR-1:0] exp_b;
        logic [MAXR-1:0] prev_blk;
        bit              exp_l, prev_hold, prev_last, fin, fire_in, fire_blk;
        int              wi, cyc, stall_left;
        for (int i = 0; i < nw; i++) begin
            w = {$urandom, $urandom};
            words.push_back(w);
            for (int b = 0; b < NB; b++)
                if (i < nw - 1 || b < bn) msg.push_back(w[8*b +: 8]);
        end
        build_expected(md, msg);
        last_blk = '0;
        nblk     = 0;

        // start with a competing in_valid: start must win
        @(negedge clk);
        bif.start     = 1'b1;
        bif.mode      = md;
        bif.in_valid  = 1'b1;
        bif.in        = {$urandom, $urandom};
        bif.is_last   = 1'b1;
        bif.byte_num  = '0;
        bif.blk_ready = 1'b0;
        @(negedge clk);
        bif.start = 1'b0;
        chk("busy after start", bif.busy, 1);
        chk("ack after start", bif.ack, 1);

        wi = 0; cyc = 0; stall_left = stall;
        prev_hold = 0; prev_last = 0; fin = 0; prev_blk = '0;
        while (!fin && cyc < 4000) begin
            chk("done", bif.done, prev_last);
            if (prev_last) fin = 1;
            if (prev_hold) begin
                chk_blk("blk held", bif.blk, prev_blk);
                chk("valid held", bif.blk_valid, 1);
            end
            if (bif.blk_valid) chk("ack while full", bif.ack, 0);

            bif.in_valid = (wi < nw) && ($urandom_range(0, 99) < vld_pct) && !fin;
            if (wi < nw) begin
                bif.in       = words[wi];
                bif.is_last  = (wi == nw - 1);
                bif.byte_num = (wi == nw - 1) ? 4'(bn) : 4'($urandom_range(0, 8));
            end
            if (bif.blk_valid && stall_left > 0) begin
                bif.blk_ready = 1'b0;
                stall_left--;
            end else begin
                bif.blk_ready = ($urandom_range(0, 99) < rdy_pct);
            end

            fire_in  = bif.in_valid && bif.ack;
            fire_blk = bif.blk_valid && bif.blk_ready;
            prev_last = 0;
            if (fire_in) wi++;
            if (fire_blk) begin
                if (exp_blk_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra block: got blk_last=%0b expected no block", bif.blk_last);
                end else begin
                    exp_b = exp_blk_q.pop_front();
                    exp_l = exp_last_q.pop_front();
                    chk_blk("block data", bif.blk, exp_b);
                    chk("blk_last", bif.blk_last, exp_l);
                    prev_last = exp_l;
                end
                last_blk = bif.blk;
                nblk++;
            end
            prev_hold = bif.blk_valid && !bif.blk_ready;
            prev_blk  = bif.blk;
            @(negedge clk);
            cyc++;
        end
        bif.in_valid  = 1'b0;
        bif.blk_ready = 1'b0;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL msg timeout: ran %0d cycles, expected done", cyc);
        end
        chk("blocks left", exp_blk_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1);
    end

    initial begin
        logic [MAXR-1:0] lb;
        int              nb;
        int              cyc;

        //          mode  nw  bn stall abrt blks sfx_i sfx_v  end_i end_v
        vecs[0] = '{3'd1,  1, 0,  0,   0,   1,   0,   8'h06, 135, 8'h80};
        vecs[1] = '{3'd3,  9, 8, 10,   0,   2,   0,   8'h06,  71, 8'h80};
        vecs[2] = '{3'd3,  9, 7,  0,   0,   1,  71,   8'h86,  71, 8'h86};
        vecs[3] = '{3'd4,  3, 3,  0,   0,   1,  19,   8'h1F, 167, 8'h80};
        vecs[4] = '{3'd0, 18, 8,  0,   0,   2,   0,   8'h06, 143, 8'h80};
        vecs[5] = '{3'd5, 17, 0,  0,   0,   1, 128,   8'h1F, 135, 8'h80};
        vecs[6] = '{3'd7,  2, 8,  0,   0,   1,  16,   8'h06, 135, 8'h80};
        vecs[7] = '{3'd2, 13, 5,  0,   0,   1, 101,   8'h06, 103, 8'h80};
        vecs[8] = '{3'd4, 21, 7,  0,   0,   1, 167,   8'h9F, 167, 8'h9F};
        vecs[9] = '{3'd5, 20, 4,  0,   1,   2,  20,   8'h1F, 135, 8'h80};

        rst           = 1'b1;
        bif.start     = 1'b0;
        bif.mode      = '0;
        bif.in_valid  = 1'b0;
        bif.in        = '0;
        bif.is_last   = 1'b0;
        bif.byte_num  = '0;
        bif.blk_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset ack", bif.ack, 0);
        chk_blk("reset blk", bif.blk, '0);
        chk("reset blk_valid", bif.blk_valid, 0);
        chk("reset blk_last", bif.blk_last, 0);
        chk("reset busy", bif.busy, 0);
        chk("reset done", bif.done, 0);
        rst = 1'b0;

        // in_valid in IDLE is ignored
        bif.in_valid = 1'b1;
        bif.in       = {$urandom, $urandom};
        repeat (2) @(negedge clk);
        chk("idle ack", bif.ack, 0);
        chk("idle busy", bif.busy, 0);
        bif.in_valid = 1'b0;

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].abort_pre) begin
                // partial SHA3-384 message, later aborted by a new start
                @(negedge clk);
                bif.start = 1'b1;
                bif.mode  = 3'd2;
                @(negedge clk);
                bif.start = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    bif.in_valid = 1'b1;
                    bif.in       = {$urandom, $urandom};
                    bif.is_last  = 1'b0;
                    @(negedge clk);
                end
                bif.in_valid = 1'b0;
                chk("busy mid message", bif.busy, 1);
            end
            run_msg(vecs[i].mode, vecs[i].nw, vecs[i].bn, 70, 80, vecs[i].stall, lb, nb);
            chk($sformatf("vec%0d blocks", i), nb, vecs[i].blocks);
            chk($sformatf("vec%0d suffix byte", i), lb[8*vecs[i].sfx_idx +: 8], vecs[i].sfx_val);
            chk($sformatf("vec%0d end byte", i), lb[8*vecs[i].end_idx +: 8], vecs[i].end_val);
            if (vecs[i].mode == 3'd0)
                chk($sformatf("vec%0d above rate", i), {63'd0, |lb[MAXR-1:1152]}, 0);
        end

        // asynchronous reset while a block is waiting
        @(negedge clk);
        bif.start = 1'b1;
        bif.mode  = 3'd1;
        @(negedge clk);
        bif.start    = 1'b0;
        bif.in_valid = 1'b1;
        bif.in       = {$urandom, $urandom};
        bif.is_last  = 1'b1;
        bif.byte_num = 4'd0;
        cyc = 0;
        while (!bif.blk_valid && cyc < 10) begin
            @(negedge clk);
            bif.in_valid = 1'b0;
            cyc++;
        end
        chk("valid before rst", bif.blk_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("async rst ack", bif.ack, 0);
        chk_blk("async rst blk", bif.blk, '0);
        chk("async rst blk_valid", bif.blk_valid, 0);
        chk("async rst blk_last", bif.blk_last, 0);
        chk("async rst busy", bif.busy, 0);
        chk("async rst done", bif.done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("after rst busy", bif.busy, 0);

        for (int m = 0; m < 25; m++) begin
            run_msg(3'($urandom_range(0, 7)), $urandom_range(1, 45), $urandom_range(0, 8),
                    60, 70, 0, lb, nb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sponge_padder.md
# sponge_padder

Parametrised absorb front-end for the Keccak sponge hash. It accepts an IN_W-bit message stream with a valid/ack handshake, assembles full rate-sized blocks, and applies SHA-3/SHAKE pad10*1 padding with a domain suffix. Byte-granular message ends are supported. Each finished block is presented to the permutation core over a valid/ready interface. Replaces the fixed 64-bit, SHA3-only padder and adds SHAKE modes, partial last words, backpressure and the extra pad-only block.

## Interface
- IN_W, 64: input word width; must be 32 or 64 so it divides every rate.
- MAX_RATE, 1344: block width in bits (largest rate, SHAKE128).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin new message; latches mode; aborts any message in progress.
- mode  in  3  0 SHA3-224, 1 SHA3-256, 2 SHA3-384, 3 SHA3-512, 4 SHAKE128, 5 SHAKE256; 6/7 treated as 1.
- in_valid  in  1  input word valid.
- in  in  IN_W  message word; byte k at bits [8k+7:8k] (little-endian).
- is_last  in  1  qualifies the final word of the message.
- byte_num  in  $clog2(IN_W/8)+1  valid bytes in the last word (0..IN_W/8); ignored unless is_last.
- ack  out  1  input accepted when in_valid & ack.
- blk  out  MAX_RATE  padded block; word i at bits [i*IN_W +: IN_W]; bits at and above the rate are 0.
- blk_valid  out  1  blk available.
- blk_ready  in  1  permutation core accepts blk.
- blk_last  out  1  final block of the message.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when the final block is accepted.

## Operation
- Rates in bits / IN_W=64 word counts: 1152/18, 1088/17, 832/13, 576/9, 1344/21, 1088/17. Domain suffix is 0x06 for SHA3 and 0x1F for SHAKE.
- States:
  - IDLE: ack=0. start goes to ABSORB, cnt=0, buffer cleared.
  - ABSORB: ack=1. The accepted word is written at index cnt.
    - Non-last word: if cnt==words-1, go to FULL with blk_last=0; else cnt++.
    - Last word: bytes >= byte_num are zeroed. The suffix is ORed into byte (cnt*IN_W/8 + byte_num) and 0x80 into byte RATE/8-1.
    - Exception: cnt==words-1 and byte_num==IN_W/8 means the suffix does not fit. Load FULL with blk_last=0 and set pend_pad.
    - Otherwise go to FULL with blk_last=1.
  - FULL: blk_valid=1, ack=0. blk and blk_last are held stable until blk_ready.
    - blk_ready with blk_last: go to IDLE and pulse done.
    - blk_ready with pend_pad: load pad-only block (suffix at byte 0, 0x80 at byte RATE/8-1), blk_last=1, clear pend_pad, stay in FULL.
    - blk_ready otherwise: go to ABSORB with cnt=0 and buffer cleared.
- When suffix and 0x80 land on the same byte, the byte is ORed (0x86 / 0x9F).
- is_last with byte_num=0 places the suffix at byte 0 of the current word, which covers the empty message.
- start in any state restarts: cnt=0, pend_pad=0, blk_valid=0, new mode latched. start takes priority over an in_valid in the same cycle.
- in_valid while ack=0 is ignored. The source must hold in until ack.

## Timing
- Reset values: ack 0, blk 0, blk_valid 0, blk_last 0, busy 0, done 0; state IDLE, cnt 0, pend_pad 0.
- ack is combinational from state; it is never combinational from in_valid.
- One word absorbed per cycle in ABSORB. blk_valid rises the cycle after the final word of a block is accepted.
- After blk_ready, ack returns the next cycle, giving a one-cycle bubble per block.
- The pad-only block is valid the cycle after the preceding block is accepted.
- done is high in the cycle following the final blk_valid & blk_ready.
- Asynchronous rst mid-operation clears all outputs immediately, without waiting for clk.

## Structure
- Package sponge_pkg holds:
  - mode encodings;
  - function rate_words(mode, IN_W);
  - suffix constants SFX_SHA3=8'h06 and SFX_SHAKE=8'h1F, plus PAD_END=8'h80;
  - MAX_RATE;
  - state enum.
- Sub-module sponge_pad_word: combinational function of (in, byte_num, suffix, is_final_word_of_rate) that returns the masked, padded word.

## Test plan
- SHA3-256, start, then one word with is_last and byte_num=0 -> one block: byte0=0x06, byte135=0x80, rest 0, blk_last=1; done after blk_ready.
- SHA3-512, 9 full words, last with byte_num=8 -> block1 = the data with blk_last=0; block2 = byte0 0x06, byte71 0x80, blk_last=1.
- SHA3-512, 9 words, last with byte_num=7 -> single block with byte71=0x86 and blk_last=1.
- SHAKE128, 3 words, last byte_num=3 -> bytes 19..23 zeroed except byte19=0x1F; byte167=0x80; SHA3-224 block check shows bits >= 1152 all 0.
- Hold blk_ready low for 10 cycles with in_valid toggling -> blk stable, ack=0, no words lost or absorbed; release gives correct continuation.
- start after 5 words of SHA3-384 with mode=SHAKE256 -> cnt restarts and SHAKE256 rate/suffix are used; rst in FULL -> all outputs 0 within the same cycle.
